// File: rtl/v68k_bus_pkg.sv
// Shared definitions for V68k bus responders: handshake state encoding,
// default geometry and byte-lane bit positions.
package v68k_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } bus_state_e;

    localparam int DEF_ADDR_BITS   = 10;
    localparam int DEF_WAIT_STATES = 2;
    localparam int WAIT_CNT_BITS   = 4;

    localparam int UPPER_MSB = 15;
    localparam int UPPER_LSB = 8;
    localparam int LOWER_MSB = 7;
    localparam int LOWER_LSB = 0;

endpackage

// File: rtl/v68k_ram_array.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port. Contents are never reset.
module v68k_ram_array
    import v68k_bus_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [1:0]           be_i,
    input  logic [15:0]          wdata_i,
    input  logic                 re_i,
    output logic [15:0]          rdata_o
);

    logic [15:0] mem_q [2**ADDR_BITS];
    logic [15:0] rdata_q;

    // Byte-laned write and registered full-word read.
    always_ff @(posedge clk_i) begin
        if (be_i[1]) begin
            mem_q[addr_i][UPPER_MSB:UPPER_LSB] <= wdata_i[UPPER_MSB:UPPER_LSB];
        end
        if (be_i[0]) begin
            mem_q[addr_i][LOWER_MSB:LOWER_LSB] <= wdata_i[LOWER_MSB:LOWER_LSB];
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/v68k_bus_ram.sv
// V68k asynchronous-bus RAM responder: window decode, AS/DS handshake FSM,
// wait-state counter and data-bus tristate control around one RAM array.
//
// state | meaning
// IDLE  | bus released, watching for a hit in the window
// WAIT  | request latched, counting down wait states
// ACK   | DTACK asserted (read data on D), waiting for AS to drop
module v68k_bus_ram
    import v68k_bus_pkg::*;
#(
    parameter int          ADDR_BITS   = DEF_ADDR_BITS,
    parameter logic [23:1] BASE        = 23'h000000,
    parameter int          WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [23:1] A,
    input  logic        AS,
    input  logic        UDS,
    input  logic        LDS,
    input  logic        RW,
    inout  logic [15:0] D,
    output logic        DTACK,
    output logic        SEL
);

    bus_state_e                 state_q, state_d;
    logic [WAIT_CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]       idx_q;
    logic                       rw_q, uds_q, lds_q;
    logic                       dtack_q, sel_q, oe_q;
    logic                       hit, latch_req;
    logic [1:0]                 ram_be;
    logic                       ram_re;
    logic [15:0]                ram_rdata;

    // Window decode: upper address bits must match the base, at least one strobe.
    assign hit = AS && (UDS || LDS) && (A[23:ADDR_BITS+1] == BASE[23:ADDR_BITS+1]);

    // Next-state, counter and array-access decisions.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_req = 1'b0;
        ram_be    = 2'b00;
        ram_re    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    latch_req = 1'b1;
                    cnt_d     = WAIT_CNT_BITS'(WAIT_STATES);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (!AS) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ACK;
                    // Gated by RESET so a reset on this edge suppresses the write.
                    if (RESET) begin
                        ram_be = rw_q ? 2'b00 : {uds_q, lds_q};
                        ram_re = rw_q;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                if (!AS) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request latch and registered bus outputs.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rw_q    <= 1'b1;
            uds_q   <= 1'b0;
            lds_q   <= 1'b0;
            dtack_q <= 1'b0;
            sel_q   <= 1'b0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_req) begin
                idx_q <= A[ADDR_BITS:1];
                rw_q  <= RW;
                uds_q <= UDS;
                lds_q <= LDS;
            end
            dtack_q <= (state_d == ACK);
            sel_q   <= (state_d != IDLE);
            // state_d can only be ACK from WAIT/ACK, where rw_q is already latched.
            oe_q    <= (state_d == ACK) && rw_q;
        end
    end

    v68k_ram_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk_i   (CLK),
        .addr_i  (idx_q),
        .be_i    (ram_be),
        .wdata_i (D),
        .re_i    (ram_re),
        .rdata_o (ram_rdata)
    );

    assign DTACK = dtack_q;
    assign SEL   = sel_q;
    assign D     = oe_q ? ram_rdata : 16'hzzzz;

endmodule

// File: tb/tb_v68k_bus_ram.sv
// Two responders share one bus: dut0 (2 wait states, words 0x000-0x3FF)
// and dut1 (0 wait states, words 0x400-0x7FF). A pull-up on D makes a
// released bus read as 16'hFFFF.
module tb_v68k_bus_ram;

    localparam int          AB    = 10;
    localparam logic [23:1] BASE0 = 23'h000000;
    localparam logic [23:1] BASE1 = 23'h000400;
    localparam int          WS0   = 2;
    localparam int          WS1   = 0;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [23:1] A;
    logic        AS, UDS, LDS, RW;
    wire  [15:0] D;
    logic        tb_oe;
    logic [15:0] tb_dat;
    wire         DTACK0, SEL0, DTACK1, SEL1;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] hi_m [logic [22:0]];
    logic [7:0] lo_m [logic [22:0]];

    always #5 CLK = ~CLK;

    assign D = tb_oe ? tb_dat : 16'hzzzz;
    pullup pu_d (D);

    v68k_bus_ram #(.ADDR_BITS(AB), .BASE(BASE0), .WAIT_STATES(WS0)) dut0 (
        .CLK(CLK), .RESET(RESET), .A(A), .AS(AS), .UDS(UDS), .LDS(LDS),
        .RW(RW), .D(D), .DTACK(DTACK0), .SEL(SEL0)
    );

    v68k_bus_ram #(.ADDR_BITS(AB), .BASE(BASE1), .WAIT_STATES(WS1)) dut1 (
        .CLK(CLK), .RESET(RESET), .A(A), .AS(AS), .UDS(UDS), .LDS(LDS),
        .RW(RW), .D(D), .DTACK(DTACK1), .SEL(SEL1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic release_bus();
        AS = 1'b0; UDS = 1'b0; LDS = 1'b0; RW = 1'b1; tb_oe = 1'b0;
    endtask

    task automatic drive_req(input logic [23:1] addr, input logic rw, input logic u,
                             input logic l, input logic [15:0] wd);
        A = addr; AS = 1'b1; UDS = u; LDS = l; RW = rw;
        tb_oe = !rw; tb_dat = wd;
    endtask

    task automatic model_write(input logic [23:1] addr, input logic u, input logic l,
                               input logic [15:0] wd);
        if (u) hi_m[addr] = wd[15:8];
        if (l) lo_m[addr] = wd[7:0];
    endtask

    task automatic check_read(input string tag, input logic [23:1] addr);
        logic [15:0] m, e;
        m = 16'h0; e = 16'h0;
        if (hi_m.exists(addr)) begin m[15:8] = 8'hFF; e[15:8] = hi_m[addr]; end
        if (lo_m.exists(addr)) begin m[7:0]  = 8'hFF; e[7:0]  = lo_m[addr]; end
        if (m != 16'h0) chk(tag, {16'h0, D & m}, {16'h0, e});
    endtask

    // One full bus cycle to dut<tgt>; abort_k>0 drops AS after abort_k cycles in WAIT.
    task automatic bus_cycle(input int tgt, input logic [23:1] addr, input logic rw,
                             input logic u, input logic l, input logic [15:0] wd,
                             input int abort_k);
        int ws, cnt;
        logic got;
        ws = (tgt == 0) ? WS0 : WS1;
        @(negedge CLK);
        drive_req(addr, rw, u, l, wd);
        if (abort_k > 0) begin
            for (int k = 0; k < abort_k; k++) begin
                @(negedge CLK);
                chk("abort_no_dtack", {31'b0, (tgt == 0) ? DTACK0 : DTACK1}, 32'd0);
            end
            release_bus();
            @(negedge CLK);
            chk("abort_sel_idle", {31'b0, (tgt == 0) ? SEL0 : SEL1}, 32'd0);
        end else begin
            cnt = 0; got = 1'b0;
            while (cnt < 40 && !got) begin
                @(negedge CLK);
                cnt++;
                if (cnt == 1) chk("sel_busy", {31'b0, (tgt == 0) ? SEL0 : SEL1}, 32'd1);
                if ((tgt == 0) ? DTACK0 : DTACK1) got = 1'b1;
            end
            chk("dtack_latency", cnt, ws + 2);
            chk("other_quiet", {30'b0, (tgt == 0) ? DTACK1 : DTACK0,
                                (tgt == 0) ? SEL1 : SEL0}, 32'd0);
            if (rw) check_read("read_data", addr);
            else    model_write(addr, u, l, wd);
            release_bus();
            @(negedge CLK);
            chk("release", {14'b0, DTACK0, DTACK1, D}, {16'h0, 16'hFFFF});
        end
    endtask

    task automatic miss_cycle(input logic [23:1] addr, input logic rw, input logic [15:0] wd);
        @(negedge CLK);
        drive_req(addr, rw, 1'b1, 1'b1, wd);
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            chk("miss_quiet", {28'b0, DTACK0, DTACK1, SEL0, SEL1}, 32'd0);
            if (rw) chk("miss_d_hiz", {16'h0, D}, {16'h0, 16'hFFFF});
        end
        release_bus();
        @(negedge CLK);
    endtask

    task automatic reset_mid_ack(input logic [23:1] addr);
        int cnt;
        @(negedge CLK);
        drive_req(addr, 1'b1, 1'b1, 1'b1, 16'h0);
        cnt = 0;
        while (cnt < 40 && !DTACK0) begin
            @(negedge CLK);
            cnt++;
        end
        chk("rst_ack_reached", cnt, WS0 + 2);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_ack_outputs", {15'b0, DTACK0, SEL0, D}, {16'h0, 1'b0, 16'hFFFF});
        RESET = 1'b1;
        release_bus();
        @(negedge CLK);
    endtask

    task automatic reset_mid_wait_write(input logic [23:1] addr, input logic [15:0] wd);
        @(negedge CLK);
        drive_req(addr, 1'b0, 1'b1, 1'b1, wd);
        @(negedge CLK);
        chk("rst_wait_sel", {31'b0, SEL0}, 32'd1);
        RESET = 1'b0;
        release_bus();
        @(negedge CLK);
        chk("rst_wait_outputs", {30'b0, DTACK0, SEL0}, 32'd0);
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b0;
        A = '0; tb_dat = 16'h0;
        release_bus();
        repeat (3) @(negedge CLK);
        chk("reset_outputs", {12'b0, DTACK0, SEL0, DTACK1, SEL1, D}, {16'h0, 16'hFFFF});
        RESET = 1'b1;
        @(negedge CLK);

        // Word write/read with two wait states.
        bus_cycle(0, BASE0 + 23'd3, 1'b0, 1'b1, 1'b1, 16'hBEEF, 0);
        bus_cycle(0, BASE0 + 23'd3, 1'b1, 1'b1, 1'b1, 16'h0, 0);

        // Byte lanes.
        bus_cycle(0, BASE0 + 23'd5, 1'b0, 1'b1, 1'b1, 16'h1234, 0);
        bus_cycle(0, BASE0 + 23'd6, 1'b0, 1'b1, 1'b1, 16'h5678, 0);
        bus_cycle(0, BASE0 + 23'd5, 1'b0, 1'b1, 1'b0, 16'hAB00, 0);
        bus_cycle(0, BASE0 + 23'd6, 1'b0, 1'b0, 1'b1, 16'h00CD, 0);
        bus_cycle(0, BASE0 + 23'd5, 1'b1, 1'b1, 1'b1, 16'h0, 0);
        chk("lane_upper_word5", {16'h0, hi_m[BASE0 + 23'd5], lo_m[BASE0 + 23'd5]}, 32'hAB34);
        bus_cycle(0, BASE0 + 23'd6, 1'b1, 1'b0, 1'b1, 16'h0, 0);

        // Zero wait states.
        bus_cycle(1, BASE1 + 23'd9, 1'b0, 1'b1, 1'b1, 16'h5A5A, 0);
        bus_cycle(1, BASE1 + 23'd9, 1'b1, 1'b1, 1'b1, 16'h0, 0);

        // Misses leave both arrays alone.
        bus_cycle(0, BASE0, 1'b0, 1'b1, 1'b1, 16'h1111, 0);
        bus_cycle(1, BASE1, 1'b0, 1'b1, 1'b1, 16'h3333, 0);
        miss_cycle(23'h000800, 1'b0, 16'h2222);
        miss_cycle(23'h7FFFFF, 1'b1, 16'h0);
        bus_cycle(0, BASE0, 1'b1, 1'b1, 1'b1, 16'h0, 0);
        bus_cycle(1, BASE1, 1'b1, 1'b1, 1'b1, 16'h0, 0);

        // Abort during WAIT.
        bus_cycle(0, BASE0 + 23'd7, 1'b0, 1'b1, 1'b1, 16'h0000, 0);
        bus_cycle(0, BASE0 + 23'd7, 1'b0, 1'b1, 1'b1, 16'hFFFF, 2);
        bus_cycle(0, BASE0 + 23'd7, 1'b1, 1'b1, 1'b1, 16'h0, 0);

        // Reset in ACK and in WAIT.
        reset_mid_ack(BASE0 + 23'd3);
        bus_cycle(0, BASE0 + 23'd3, 1'b1, 1'b1, 1'b1, 16'h0, 0);
        reset_mid_wait_write(BASE0 + 23'd3, 16'h0BAD);
        bus_cycle(0, BASE0 + 23'd3, 1'b1, 1'b1, 1'b1, 16'h0, 0);

        // Randomized traffic against the word/byte model.
        for (int i = 0; i < 80; i++) begin
            int          tgt, ws, ab, lanes;
            logic [23:1] addr;
            logic        rw;
            logic [15:0] wd;
            rw = 1'($urandom);
            wd = 16'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                miss_cycle(23'($urandom_range(32'h800, 32'h7FFFFF)), rw, wd);
            end else begin
                tgt   = int'($urandom_range(0, 1));
                ws    = (tgt == 0) ? WS0 : WS1;
                addr  = ((tgt == 0) ? BASE0 : BASE1) + 23'($urandom_range(0, 15));
                lanes = int'($urandom_range(1, 3));
                ab    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, ws + 1)) : 0;
                bus_cycle(tgt, addr, rw, lanes[1], lanes[0], wd, ab);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/v68k_bus_ram.md
# v68k_bus_ram

Word-wide RAM responder for the V68k asynchronous bus, the slave end of the CPU's AS/UDS/LDS/RW/DTACK handshake. Decodes a base-aligned window of the 23-bit word address space, performs byte-laned reads and writes against an internal array, and asserts DTACK after a fixed number of wait states. It sits on the shared A/D bus beside other responders and stays silent for addresses outside its window.

## Interface
Parameters:
- ADDR_BITS, 10, word-address bits decoded into the array (depth 2^ADDR_BITS words).
- BASE, 23'h000000, window base in word-address units; low ADDR_BITS bits ignored.
- WAIT_STATES, 2, extra clocks between request sample and DTACK (0..15).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous reset, active-low.
- A  in  23  word address A[23:1].
- AS  in  1  address strobe, high = address valid.
- UDS  in  1  upper byte strobe, high = D[15:8] lane active.
- LDS  in  1  lower byte strobe, high = D[7:0] lane active.
- RW  in  1  high = read, low = write.
- D  inout  16  data bus; driven only during read acknowledge, else high-Z.
- DTACK  out  1  high = data transfer acknowledged.
- SEL  out  1  high while this block owns the current cycle (debug/arbitration).

## Operation
- Hit: AS high, (UDS|LDS) high, A[23:ADDR_BITS+1] == BASE[23:ADDR_BITS+1].
- States: IDLE, WAIT, ACK.
- IDLE: on hit, latch word index A[ADDR_BITS:1], RW, UDS, LDS; load wait counter = WAIT_STATES; go WAIT. AS high with no strobes: stay IDLE. Miss: stay IDLE, never drive D or DTACK.
- WAIT: AS low -> IDLE (abort, no array access). Counter 0 -> ACK; else decrement.
- WAIT->ACK edge: write: array[idx] byte lanes updated from D where latched UDS/LDS set; unset lanes untouched. Read: read register loaded with array[idx] (full word; unstrobed lane still driven).
- ACK: DTACK=1; read cycles drive D from read register. AS low -> IDLE. Address/strobe changes while AS high are ignored (latched values used).
- SEL = 1 in WAIT and ACK.
- Reset outputs: DTACK=0, SEL=0, D high-Z, state IDLE, counter 0. Array contents not cleared by reset; power-up contents undefined.
- Reset mid-cycle (any state): next edge IDLE with outputs at reset values; a write not yet at the WAIT->ACK edge is not performed.

## Timing
- Request sampled at edge n (IDLE). DTACK and read data valid after edge n+WAIT_STATES+1; WAIT_STATES=0 -> after edge n+1.
- DTACK held until the edge that samples AS low; DTACK=0 and D high-Z after that edge (one-cycle release).
- Back-to-back: new hit sampled no earlier than the edge after returning to IDLE; minimum cycle WAIT_STATES+3 clocks.
- Write data sampled from D only on the WAIT->ACK edge; master must hold D stable from AS assertion through DTACK.
- All outputs registered; no combinational path from bus inputs to DTACK or D.

## Structure
- Shared package v68k_bus_pkg: state encodings (IDLE/WAIT/ACK), default ADDR_BITS/WAIT_STATES, byte-lane index constants (UPPER=15:8, LOWER=7:0). Reused by future responders (ROM, peripherals).
- Sub-module v68k_ram_array: single-port synchronous RAM, 16-bit, two byte-write enables, registered read; instantiated once.
- FSM, decode, counter and tristate control in v68k_bus_ram.

## Test plan
- Word write/read, WAIT_STATES=2: write 16'hBEEF to word 3 (RW=0, UDS=LDS=1) -> DTACK 3 edges after sample; read word 3 -> D=16'hBEEF with DTACK.
- Byte lanes: word 5 = 16'h1234; write 16'hAB00 UDS only, then 16'h00CD LDS only to word 6=16'h5678 -> reads 16'hAB34 and 16'h56CD.
- WAIT_STATES=0: read sampled at edge n -> DTACK after edge n+1; AS dropped -> DTACK low, D high-Z next edge.
- Miss: A outside window, AS/UDS/LDS high 20 cycles -> DTACK=0, SEL=0, D high-Z throughout; array unchanged.
- Abort: write 16'hFFFF to word 7 (prior 16'h0000), AS low during WAIT -> no DTACK; read word 7 returns 16'h0000.
- Reset mid-ACK: RESET low during read ACK -> next edge DTACK=0, D high-Z, SEL=0; prior written data still readable after reset.
